geofence_seq: RTL and testbench

- Control FSM for the geofence datapath.
- Per object it:
  - captures the 6 receiver samples (X, Y, R);
  - sequences the angular sort of receivers 1..5 around receiver 0 through a shared cross-product comparator;
  - sequences the shoelace hexagon-area accumulation;
  - sequences the 6 sqrt + Heron triangle steps;
  - then reports valid/is_inside.
- Sits between the top-level geofence ports and the arithmetic datapath. It owns no arithmetic itself.

---
 rtl/geofence_pkg.sv | 31 +++
 rtl/geofence_seq_if.sv | 64 ++++++
 rtl/geofence_pair_iter.sv | 55 +++++
 rtl/geofence_seq.sv | 175 +++++++++++++++++
 tb/tb_geofence_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/geofence_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_pkg
//  Description : Shared constants and the state type for the geofence
//                sequencer. NPTS/IDX_W size every index; NPAIRS is the number
//                of (i,j) pairs visited by the angular sort; WDOG_MAX is the
//                handshake timeout used when GEOF_WDOG_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package geofence_pkg;

    localparam int NPTS     = 6;
    localparam int IDX_W    = 3;
    localparam int NPAIRS   = 10;
    localparam int WDOG_MAX = 255;
    localparam int WDOG_W   = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        SORT   = 3'd1,
        AREA   = 3'd2,
        TRI_SQ = 3'd3,
        TRI_ST = 3'd4,
        CMP    = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage : geofence_pkg
`default_nettype wire

// File: rtl/geofence_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_seq_if
//  Description : Handshake bundle between the geofence sequencer (master)
//                and the arithmetic datapath (slave).
//                load_*  : sample capture strobe and slot
//                cmp_*   : cross-product compare request/ack, swap strobe
//                area_*  : shoelace accumulation step
//                sqrt_*  : side-length sqrt request/ack
//                tri_*   : Heron triangle accumulation step
//                dp_inside, valid, is_inside, err : result path
//  Revision    : 1.0  initial release
// ============================================================================
interface geofence_seq_if;
    import geofence_pkg::*;

    logic             load_en;
    logic [IDX_W-1:0] load_idx;
    logic             cmp_req;
    logic [IDX_W-1:0] cmp_a_idx;
    logic [IDX_W-1:0] cmp_b_idx;
    logic             cmp_ack;
    logic             cmp_neg;
    logic             swap_en;
    logic             area_en;
    logic             area_clr;
    logic [IDX_W-1:0] area_idx;
    logic             sqrt_req;
    logic [IDX_W-1:0] sqrt_idx;
    logic             sqrt_ack;
    logic             tri_en;
    logic             tri_clr;
    logic [IDX_W-1:0] tri_idx;
    logic             dp_inside;
    logic             valid;
    logic             is_inside;
    logic             err;

    modport master (
        output load_en, load_idx,
        output cmp_req, cmp_a_idx, cmp_b_idx, swap_en,
        input  cmp_ack, cmp_neg,
        output area_en, area_clr, area_idx,
        output sqrt_req, sqrt_idx,
        input  sqrt_ack,
        output tri_en, tri_clr, tri_idx,
        input  dp_inside,
        output valid, is_inside, err
    );

    modport slave (
        input  load_en, load_idx,
        input  cmp_req, cmp_a_idx, cmp_b_idx, swap_en,
        output cmp_ack, cmp_neg,
        input  area_en, area_clr, area_idx,
        input  sqrt_req, sqrt_idx,
        output sqrt_ack,
        input  tri_en, tri_clr, tri_idx,
        output dp_inside,
        input  valid, is_inside, err
    );

endinterface : geofence_seq_if
`default_nettype wire

// File: rtl/geofence_pair_iter.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_pair_iter
//  Description : Walks the sort pairs (i,j), i=1..NPTS-2, j=i+1..NPTS-1 in
//                lexicographic order. Wraps back to (1,2) after the last pair.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                clr         - park the iterator on the first pair
//                advance     - step to the next pair
//                idx_i/idx_j - current pair
//                first/last  - current pair is (1,2) / (NPTS-2,NPTS-1)
//  Revision    : 1.0  initial release
// ============================================================================
module geofence_pair_iter
    import geofence_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clr,
    input  wire logic             advance,
    output logic      [IDX_W-1:0] idx_i,
    output logic      [IDX_W-1:0] idx_j,
    output logic                  first,
    output logic                  last
);

    localparam logic [IDX_W-1:0] c_I0 = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_J0 = IDX_W'(2);

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_i <= c_I0;
            r_j <= c_J0;
        end else if (advance) begin
            if (last) begin
                r_i <= c_I0;
                r_j <= c_J0;
            end else if (r_j == LAST_IDX) begin
                r_i <= r_i + IDX_W'(1);
                r_j <= r_i + IDX_W'(2);
            end else begin
                r_j <= r_j + IDX_W'(1);
            end
        end
    end

    assign idx_i = r_i;
    assign idx_j = r_j;
    assign first = (r_i == c_I0) && (r_j == c_J0);
    assign last  = (r_i == LAST_IDX - IDX_W'(1)) && (r_j == LAST_IDX);

endmodule : geofence_pair_iter
`default_nettype wire

// File: rtl/geofence_seq.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_seq
//  Description : Control FSM for the geofence datapath. Per object: capture
//                6 samples, angular sort of receivers 1..5 about receiver 0,
//                shoelace hexagon area, 6 sqrt + Heron triangle steps, then a
//                one-cycle valid with is_inside. No arithmetic lives here.
//  Ports       : clk   - clock
//                reset - synchronous, active-high; abandons any object
//                bus   - geofence_seq_if.master (all handshake signals)
//  Options     : GEOF_WDOG_EN - when defined, a request left unacknowledged
//                for WDOG_MAX cycles ends the object with valid=1, err=1,
//                is_inside=0. Otherwise err is 0 and the FSM waits forever.
//  Revision    : 1.0  initial release
// ============================================================================
module geofence_seq
    import geofence_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    geofence_seq_if.master bus
);

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_is_inside;
    logic             r_err;

    logic [IDX_W-1:0] w_pair_i;
    logic [IDX_W-1:0] w_pair_j;
    logic             w_pair_first;
    logic             w_pair_last;
    logic             w_cmp_done;
    logic             w_sqrt_done;
    logic             w_wdog_fire;
    logic             w_run;

    // Outputs are forced low while reset is asserted so the datapath never
    // sees a strobe from an object that is being abandoned.
    assign w_run       = ~reset;
    assign w_cmp_done  = (r_state == SORT)   && bus.cmp_ack;
    assign w_sqrt_done = (r_state == TRI_SQ) && bus.sqrt_ack;

    // Iterator is held on the first pair outside SORT, so an object cut
    // short (reset or timeout) always restarts the sort from (1,2).
    geofence_pair_iter u_pair_iter (
        .clk     (clk),
        .reset   (reset),
        .clr     ((r_state != SORT) && !w_pair_first),
        .advance (w_cmp_done),
        .idx_i   (w_pair_i),
        .idx_j   (w_pair_j),
        .first   (w_pair_first),
        .last    (w_pair_last)
    );

`ifdef GEOF_WDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              w_waiting;

    assign w_waiting   = ((r_state == SORT)   && !bus.cmp_ack) ||
                         ((r_state == TRI_SQ) && !bus.sqrt_ack);
    // Fires on the wait cycle at which the count would reach WDOG_MAX.
    assign w_wdog_fire = w_waiting && (r_wdog == WDOG_W'(WDOG_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset || !w_waiting || w_wdog_fire) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_is_inside <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_wdog_fire) begin
            r_state     <= DONE;
            r_cnt       <= '0;
            r_is_inside <= 1'b0;
            r_err       <= 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    if (r_cnt == LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= SORT;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                SORT: begin
                    if (w_cmp_done && w_pair_last) begin
                        r_state <= AREA;
                    end
                end
                AREA: begin
                    if (r_cnt == LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= TRI_SQ;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                TRI_SQ: begin
                    if (w_sqrt_done) begin
                        r_state <= TRI_ST;
                    end
                end
                TRI_ST: begin
                    if (r_cnt == LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= CMP;
                    end else begin
                        r_cnt   <= r_cnt + IDX_W'(1);
                        r_state <= TRI_SQ;
                    end
                end
                CMP: begin
                    r_is_inside <= bus.dp_inside;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= LOAD;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= LOAD;
                end
            endcase
        end
    end

    logic w_load;
    logic w_sort;
    logic w_area;
    logic w_sq;
    logic w_tri;
    logic w_done;

    assign w_load = w_run && (r_state == LOAD);
    assign w_sort = w_run && (r_state == SORT);
    assign w_area = w_run && (r_state == AREA);
    assign w_sq   = w_run && (r_state == TRI_SQ);
    assign w_tri  = w_run && (r_state == TRI_ST);
    assign w_done = w_run && (r_state == DONE);

    assign bus.load_en   = w_load;
    assign bus.load_idx  = w_load ? r_cnt : '0;
    assign bus.cmp_req   = w_sort;
    assign bus.cmp_a_idx = w_sort ? w_pair_i : '0;
    assign bus.cmp_b_idx = w_sort ? w_pair_j : '0;
    // Mealy: the swap happens in the very cycle the compare result arrives.
    assign bus.swap_en   = w_sort && bus.cmp_ack && bus.cmp_neg;
    assign bus.area_en   = w_area;
    assign bus.area_clr  = w_area && (r_cnt == '0);
    assign bus.area_idx  = w_area ? r_cnt : '0;
    assign bus.sqrt_req  = w_sq;
    assign bus.sqrt_idx  = w_sq ? r_cnt : '0;
    assign bus.tri_en    = w_tri;
    assign bus.tri_clr   = w_tri && (r_cnt == '0);
    assign bus.tri_idx   = w_tri ? r_cnt : '0;
    assign bus.valid     = w_done;
    assign bus.is_inside = w_run && r_is_inside;
    assign bus.err       = w_done && r_err;

endmodule : geofence_seq
`default_nettype wire

// File: tb/tb_geofence_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_geofence_seq
//  Description : Self-checking bench for geofence_seq. A timeline model
//                predicts every strobe (kind, indices, flags, cycle within the
//                object) and queues it; a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_geofence_seq;
    import geofence_pkg::*;

    localparam int K_LOAD = 0, K_CMP = 1, K_AREA = 2, K_SQ = 3, K_TRI = 4, K_VALID = 5;
    localparam int HANG = 1000000;

    typedef struct {
        int kind;
        int a;
        int b;
        int f;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    geofence_seq_if bus ();

    geofence_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  mon_cyc = 0;
    int  exp_hold = 0;

    // Per-object stimulus configuration.
    bit  cfg_neg[NPAIRS];
    int  cfg_cd[NPAIRS];
    int  cfg_sd[NPTS];
    bit  cfg_dp;
    bit  cfg_strays;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Timeline of one object derived from the sequencing rules: 6 loads,
    // 10 compares each taking 1+delay cycles, 6 area steps, 6 sqrt waits
    // each followed by a triangle step, one compare cycle, then valid.
    task automatic push_model(input bit hang);
        int t;
        int p;
        ev_t e;
        for (int i = 0; i < NPTS; i++) begin
            e = '{K_LOAD, i, 0, 0, i + 1};
            exp_q.push_back(e);
        end
        t = 7;
        p = 0;
        for (int i = 1; i <= 4; i++) begin
            for (int j = i + 1; j <= 5; j++) begin
                t += cfg_cd[p];
                e = '{K_CMP, i, j, int'(cfg_neg[p]), t};
                exp_q.push_back(e);
                t++;
                p++;
            end
        end
        for (int i = 0; i < NPTS; i++) begin
            e = '{K_AREA, i, 0, (i == 0) ? 1 : 0, t};
            exp_q.push_back(e);
            t++;
        end
        if (hang) begin
`ifdef GEOF_WDOG_EN
            e = '{K_VALID, 0, 1, 0, t + 255};
            exp_q.push_back(e);
`endif
            return;
        end
        for (int k = 0; k < NPTS; k++) begin
            t += cfg_sd[k];
            e = '{K_SQ, k, 0, 0, t};
            exp_q.push_back(e);
            t++;
            e = '{K_TRI, k, 0, (k == 0) ? 1 : 0, t};
            exp_q.push_back(e);
            t++;
        end
        t++;
        e = '{K_VALID, int'(cfg_dp), 0, 0, t};
        exp_q.push_back(e);
    endtask

    // Responder for one object. Acks come after cfg_*d extra cycles of
    // request; stray acks and junk cmp_neg are injected when cfg_strays.
    task automatic run_obj(input int abort_k, input int max_cyc,
                           output bit got_valid, output bit aborted);
        int ci = 0, cw = 0, si = 0, sw = 0;
        got_valid = 1'b0;
        aborted   = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge clk);
            #1;
            bus.cmp_ack   = 1'b0;
            bus.sqrt_ack  = 1'b0;
            bus.cmp_neg   = 1'($urandom);
            bus.dp_inside = cfg_dp;
            if (bus.valid) begin
                got_valid = 1'b1;
                return;
            end
            if (bus.sqrt_req && int'(bus.sqrt_idx) == abort_k) begin
                aborted = 1'b1;
                return;
            end
            if (bus.cmp_req) begin
                if (ci < NPAIRS && cw >= cfg_cd[ci]) begin
                    bus.cmp_ack = 1'b1;
                    bus.cmp_neg = cfg_neg[ci];
                    ci++;
                    cw = 0;
                end else begin
                    cw++;
                end
            end else if (cfg_strays) begin
                bus.cmp_ack = ($urandom_range(3) == 0);
            end
            if (bus.sqrt_req) begin
                if (si < NPTS && sw >= cfg_sd[si]) begin
                    bus.sqrt_ack = 1'b1;
                    si++;
                    sw = 0;
                end else begin
                    sw++;
                end
            end else if (cfg_strays) begin
                bus.sqrt_ack = ($urandom_range(3) == 0);
            end
        end
    endtask

    task automatic set_cfg(input int cmax, input int smax, input bit dp, input bit strays);
        for (int p = 0; p < NPAIRS; p++) begin
            cfg_neg[p] = 1'($urandom);
            cfg_cd[p]  = $urandom_range(cmax);
        end
        for (int k = 0; k < NPTS; k++) cfg_sd[k] = $urandom_range(smax);
        cfg_dp     = dp;
        cfg_strays = strays;
    endtask

    task automatic drained(input string name);
        @(negedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops one expected event per strobe and audits idle outputs.
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (reset) begin
            check("reset_outputs_zero",
                  int'({bus.load_en, bus.load_idx, bus.cmp_req, bus.cmp_a_idx, bus.cmp_b_idx,
                        bus.swap_en, bus.area_en, bus.area_clr, bus.area_idx, bus.sqrt_req,
                        bus.sqrt_idx, bus.tri_en, bus.tri_clr, bus.tri_idx, bus.valid,
                        bus.is_inside, bus.err} != '0), 0);
            exp_hold = 0;
            mon_cyc  = 0;
        end else begin
            mon_cyc++;
            if (bus.load_en && bus.load_idx == '0) mon_cyc = 1;
            kind = -1;
            if (bus.load_en)                      kind = K_LOAD;
            else if (bus.cmp_req && bus.cmp_ack)  kind = K_CMP;
            else if (bus.area_en)                 kind = K_AREA;
            else if (bus.sqrt_req && bus.sqrt_ack) kind = K_SQ;
            else if (bus.tri_en)                  kind = K_TRI;
            else if (bus.valid)                   kind = K_VALID;
            if (kind >= 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe_kind", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", kind, e.kind);
                    check("strobe_cycle", mon_cyc, e.cyc);
                    case (kind)
                        K_LOAD: check("load_idx", int'(bus.load_idx), e.a);
                        K_CMP: begin
                            check("cmp_a_idx", int'(bus.cmp_a_idx), e.a);
                            check("cmp_b_idx", int'(bus.cmp_b_idx), e.b);
                            check("swap_en", int'(bus.swap_en), e.f);
                        end
                        K_AREA: begin
                            check("area_idx", int'(bus.area_idx), e.a);
                            check("area_clr", int'(bus.area_clr), e.f);
                        end
                        K_SQ: check("sqrt_idx", int'(bus.sqrt_idx), e.a);
                        K_TRI: begin
                            check("tri_idx", int'(bus.tri_idx), e.a);
                            check("tri_clr", int'(bus.tri_clr), e.f);
                        end
                        default: begin
                            check("valid_err", int'(bus.err), e.b);
                            exp_hold = e.a;
                        end
                    endcase
                end
            end
            check("idle_outputs_zero",
                  int'((!bus.load_en && bus.load_idx != '0) ||
                       (!bus.cmp_req && (bus.cmp_a_idx != '0 || bus.cmp_b_idx != '0)) ||
                       (bus.swap_en && !(bus.cmp_req && bus.cmp_ack && bus.cmp_neg)) ||
                       (!bus.area_en && (bus.area_idx != '0 || bus.area_clr)) ||
                       (!bus.sqrt_req && bus.sqrt_idx != '0) ||
                       (!bus.tri_en && (bus.tri_idx != '0 || bus.tri_clr)) ||
                       (!bus.valid && bus.err)), 0);
            check("is_inside", int'(bus.is_inside), exp_hold);
        end
    end

    initial begin
        bit got;
        bit ab;
        bus.cmp_ack   = 1'b0;
        bus.cmp_neg   = 1'b0;
        bus.sqrt_ack  = 1'b0;
        bus.dp_inside = 1'b0;

        // Reset, then a baseline object with same-cycle acks (valid at 36).
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        set_cfg(0, 0, 1'b1, 1'b0);
        push_model(1'b0);
        run_obj(-1, 2000, got, ab);
        check("valid_seen_baseline", int'(got), 1);

        // Back to back: swaps only on pairs (1,2) and (3,5), dp_inside=0.
        set_cfg(0, 0, 1'b0, 1'b0);
        for (int p = 0; p < NPAIRS; p++) cfg_neg[p] = (p == 0 || p == 8);
        push_model(1'b0);
        run_obj(-1, 2000, got, ab);
        check("valid_seen_swaps", int'(got), 1);

        // Every sqrt acked after 4 wait cycles (valid at 60).
        set_cfg(0, 0, 1'b1, 1'b0);
        for (int k = 0; k < NPTS; k++) cfg_sd[k] = 4;
        push_model(1'b0);
        run_obj(-1, 2000, got, ab);
        check("valid_seen_sqrt_delay", int'(got), 1);
        drained("events_left_sqrt_delay");

        // Reset while waiting on the sqrt for triangle 3.
        set_cfg(2, 2, 1'b1, 1'b1);
        push_model(1'b0);
        run_obj(3, 2000, got, ab);
        check("abort_point_reached", int'(ab), 1);
        reset = 1'b1;
        bus.cmp_ack  = 1'b0;
        bus.sqrt_ack = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_cfg(1, 1, 1'b0, 1'b1);
        push_model(1'b0);
        run_obj(-1, 2000, got, ab);
        check("valid_seen_after_abort", int'(got), 1);

        // Randomised objects run back to back with stray acks.
        for (int o = 0; o < 6; o++) begin
            set_cfg(3, 3, 1'($urandom), 1'b1);
            push_model(1'b0);
            run_obj(-1, 2000, got, ab);
            check("valid_seen_random", int'(got), 1);
        end
        drained("events_left_random");

        // sqrt never acknowledged.
        set_cfg(0, 0, 1'b1, 1'b0);
        cfg_sd[0] = HANG;
        push_model(1'b1);
        run_obj(-1, 400, got, ab);
`ifdef GEOF_WDOG_EN
        check("valid_seen_watchdog", int'(got), 1);
`else
        check("no_valid_while_hung", int'(got), 0);
`endif
        drained("events_left_hang");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_geofence_seq
`default_nettype wire
